// File: rtl/stream_word_packer_if.sv
// Handshake bundle around the word packer: narrow input stream in,
// wide packed stream out. The packer takes the slave view and the
// surrounding logic takes the master view.
interface stream_word_packer_if #(
    parameter int Width = 8,
    parameter int Ratio = 4
);
    logic [Width-1:0]       in_data;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [Width*Ratio-1:0] out_data;
    logic [Ratio-1:0]       out_keep;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/stream_word_packer.sv
// Width upsizer: packs Ratio consecutive Width-bit words into one wide word.
// A last flag closes a packet early; the partial word goes out with a
// contiguous keep mask starting at lane 0 and zeroed upper lanes.

// One accumulator lane: holds a word and its keep bit until the packet closes.
module stream_word_packer_lane #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [Width-1:0] in_data,
    output logic [Width-1:0] lane_q,
    output logic             keep_q
);
    // Clear has priority: the closing word bypasses the lane straight into the output register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane_q <= '0;
            keep_q <= 1'b0;
        end else if (load) begin
            lane_q <= in_data;
            keep_q <= 1'b1;
        end
    end
endmodule

module stream_word_packer #(
    parameter int Width = 8,
    parameter int Ratio = 4
) (
    input logic                clk,
    input logic                rst,
    stream_word_packer_if.slave bus
);
    localparam int CountWidth = $clog2(Ratio);

    logic [CountWidth-1:0]         cnt;
    logic                          accept;
    logic                          close_word;
    logic                          at_last_lane;
    logic [Ratio-1:0]              lane_sel;
    logic [Ratio-1:0]              acc_keep;
    logic [Ratio-1:0][Width-1:0]   acc_data;
    logic [Ratio-1:0][Width-1:0]   pack_data;
    logic [Ratio-1:0]              pack_keep;

    logic [Ratio-1:0][Width-1:0]   out_data_q;
    logic [Ratio-1:0]              out_keep_q;
    logic                          out_last_q;
    logic                          out_valid_q;

    // Ready only looks at the output register and out_ready, never at the input word.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign at_last_lane  = (cnt == CountWidth'(Ratio - 1));
    assign close_word    = accept && (at_last_lane || bus.in_last);

    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;

    genvar k;
    generate
        for (k = 0; k < Ratio; k++) begin : g_lane
            assign lane_sel[k] = (cnt == CountWidth'(k));

            stream_word_packer_lane #(.Width(Width)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load    (accept && lane_sel[k]),
                .clear   (close_word),
                .in_data (bus.in_data),
                .lane_q  (acc_data[k]),
                .keep_q  (acc_keep[k])
            );

            // Lanes above cnt carry no keep bit, so they are forced to zero here.
            assign pack_data[k] = lane_sel[k] ? bus.in_data
                                : (acc_keep[k] ? acc_data[k] : '0);
            assign pack_keep[k] = acc_keep[k] | lane_sel[k];
        end
    endgenerate

    // Lane counter: advances per accepted word, wraps only when a word closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (close_word) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + CountWidth'(1);
        end
    end

    // Output register: loads on a closing word (even while the old word drains), drops on pure consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (close_word) begin
            out_data_q  <= pack_data;
            out_keep_q  <= pack_keep;
            out_last_q  <= bus.in_last;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_word_packer.sv
// Directed and randomized checks of the word packer against a queue-based
// packet model: words are collected into a list and emitted when the list
// reaches four entries or a word carries last.
module tb_stream_word_packer;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } pkt_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stream_word_packer_if #(.Width(8), .Ratio(4)) bus ();

    stream_word_packer #(.Width(8), .Ratio(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  cur_q[$];
    pkt_t        exp_q[$];
    bit          rnd_ready = 0;
    bit          held = 0;
    logic [31:0] held_d;
    logic [3:0]  held_k;
    logic        held_l;
    int          n_out_last = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: collect accepted words, emit a packet at four words or on last.
    task automatic model_push(input logic [7:0] w, input logic l, output logic closed);
        pkt_t p;
        closed = 1'b0;
        cur_q.push_back(w);
        if (cur_q.size() == 4 || l) begin
            p.d = '0;
            for (int i = 0; i < cur_q.size(); i++) p.d = p.d | (32'(cur_q[i]) << (8 * i));
            p.k = 4'((1 << cur_q.size()) - 1);
            p.l = l;
            exp_q.push_back(p);
            cur_q.delete();
            closed = 1'b1;
        end
    endtask

    // One clock: check handshake, score any consumed word, advance the model.
    task automatic tick(output logic acc_o);
        logic cons, closed, exp_valid;
        pkt_t e;
        if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        chk("in_ready_eq", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        if (held) begin
            chk("stall_data", 64'(bus.out_data), 64'(held_d));
            chk("stall_keep", 64'(bus.out_keep), 64'(held_k));
            chk("stall_last", 64'(bus.out_last), 64'(held_l));
        end
        acc_o = bus.in_valid && bus.in_ready;
        cons  = bus.out_valid && bus.out_ready;
        if (cons) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'(bus.out_data), 64'(e.d));
                chk("sb_keep", 64'(bus.out_keep), 64'(e.k));
                chk("sb_last", 64'(bus.out_last), 64'(e.l));
            end
            chk("keep_contig", 64'((int'(bus.out_keep) & (int'(bus.out_keep) + 1)) == 0), 64'(1));
            if (bus.out_last) n_out_last++;
        end
        closed = 1'b0;
        if (acc_o) model_push(bus.in_data, bus.in_last, closed);
        held   = bus.out_valid && !bus.out_ready;
        held_d = bus.out_data;
        held_k = bus.out_keep;
        held_l = bus.out_last;
        exp_valid = closed || held;
        @(posedge clk);
        #1;
        chk("out_valid_next", 64'(bus.out_valid), 64'(exp_valid));
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic a;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        do begin
            tick(a);
            n++;
        end while (!a && n < 50);
        if (!a) chk("send_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_q.delete();
        exp_q.delete();
        held = 0;
    endtask

    initial begin
        logic a;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        do_reset();

        // Reset state
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data",  64'(bus.out_data),  64'(0));
        chk("rst_keep",  64'(bus.out_keep),  64'(0));
        chk("rst_last",  64'(bus.out_last),  64'(0));
        chk("rst_ready", 64'(bus.in_ready),  64'(1));
        bus.out_ready = 1'b1;

        // Full word, back to back
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("full_valid", 64'(bus.out_valid), 64'(1));
        chk("full_data",  64'(bus.out_data),  64'h44332211);
        chk("full_keep",  64'(bus.out_keep),  64'hf);
        chk("full_last",  64'(bus.out_last),  64'(0));
        tick(a);
        chk("full_one_cycle", 64'(bus.out_valid), 64'(0));

        // Early last, then a single-word packet back to back
        send(8'hA1, 0); send(8'hA2, 1);
        chk("early_data", 64'(bus.out_data), 64'h0000A2A1);
        chk("early_keep", 64'(bus.out_keep), 64'h3);
        chk("early_last", 64'(bus.out_last), 64'(1));
        send(8'h5C, 1);
        chk("single_valid", 64'(bus.out_valid), 64'(1));
        chk("single_data",  64'(bus.out_data),  64'h0000005C);
        chk("single_keep",  64'(bus.out_keep),  64'h1);
        chk("single_last",  64'(bus.out_last),  64'(1));
        tick(a);

        // Backpressure with a pending word and a waiting input
        bus.out_ready = 1'b0;
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
        chk("bp_valid", 64'(bus.out_valid), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h50;
        bus.in_last  = 1'b0;
        #1;
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        repeat (3) tick(a);
        chk("bp_data_held", 64'(bus.out_data), 64'h40302010);
        bus.out_ready = 1'b1;
        send(8'h50, 0);
        chk("bp_drained", 64'(bus.out_valid), 64'(0));
        send(8'h60, 0); send(8'h70, 0); send(8'h80, 0);
        chk("bp_next_data", 64'(bus.out_data), 64'h80706050);
        chk("bp_next_keep", 64'(bus.out_keep), 64'hf);
        tick(a);

        // Reset mid-packet discards partial lanes
        send(8'h01, 0); send(8'h02, 0);
        do_reset();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        send(8'h03, 0); send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
        chk("mid_rst_data", 64'(bus.out_data), 64'h06050403);
        chk("mid_rst_keep", 64'(bus.out_keep), 64'hf);
        tick(a);

        // Randomized streaming, last on every 7th word
        n_out_last = 0;
        rnd_ready  = 1;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) tick(a);
            send(8'($urandom), (i % 7) == 6);
        end
        rnd_ready     = 0;
        bus.out_ready = 1'b1;
        repeat (4) tick(a);
        chk("stream_drained", 64'(exp_q.size()), 64'(0));
        chk("stream_lasts",   64'(n_out_last),   64'(9));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
